// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite definitions for the fetch master: RRESP encodings, core response
// codes, FSM state encoding and small decode helpers.
package axi4lite_pkg;

  localparam logic [1:0] RRESP_OKAY   = 2'b00;
  localparam logic [1:0] RRESP_EXOKAY = 2'b01;
  localparam logic [1:0] RRESP_SLVERR = 2'b10;
  localparam logic [1:0] RRESP_DECERR = 2'b11;

  localparam logic [1:0] RSP_OK         = 2'b00;
  localparam logic [1:0] RSP_BUS_ERR    = 2'b01;
  localparam logic [1:0] RSP_TIMEOUT    = 2'b10;
  localparam logic [1:0] RSP_MISALIGNED = 2'b11;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ADDR  = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_RESP  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  // Width of the R-phase cycle counter; covers the full 2..255 timeout range.
  localparam int unsigned CTR_W = 8;

  // Anything other than a plain OKAY is reported to the core as a bus error.
  function automatic logic [1:0] rsp_code_of(input logic [1:0] rresp);
    logic [1:0] code;
    code = RSP_BUS_ERR;
    case (rresp)
      RRESP_OKAY:                                code = RSP_OK;
      RRESP_EXOKAY, RRESP_SLVERR, RRESP_DECERR:  code = RSP_BUS_ERR;
    endcase
    return code;
  endfunction

  function automatic logic is_aligned(input logic [1:0] addr_lsb);
    return addr_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/axi4lite_fetch_master_if.sv
// AXI4-Lite read-only channel bundle (AR + R) between the fetch master and a slave.
interface axi4lite_fetch_master_if;

  logic        ARVALID;
  logic [31:0] ARADDR;
  logic        ARREADY;
  logic        RVALID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RREADY;

  modport master (
    output ARVALID, ARADDR, RREADY,
    input  ARREADY, RVALID, RDATA, RRESP
  );

  modport slave (
    input  ARVALID, ARADDR, RREADY,
    output ARREADY, RVALID, RDATA, RRESP
  );

endinterface

// File: rtl/axi4lite_timeout_ctr.sv
// R-phase cycle counter: cleared outside the data phase, counts while enabled and
// parks at the limit so expired stays asserted until the next clear.
module axi4lite_timeout_ctr
  import axi4lite_pkg::*;
(
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic             clear,
  input  logic             enable,
  input  logic [CTR_W-1:0] limit,
  output logic             expired
);

  logic [CTR_W-1:0] count;

  assign expired = (count == limit);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/axi4lite_fetch_master.sv
// Single-outstanding AXI4-Lite fetch master: one core request becomes at most one AXI
// read, with misalignment trapping, an R-phase timeout and a drain of the late beat.
module axi4lite_fetch_master
  import axi4lite_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_code,
  output logic [7:0]  err_count,
  axi4lite_fetch_master_if.master bus
);

  localparam logic [CTR_W-1:0] LIMIT = CTR_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]  state;
  logic [2:0]  state_next;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [1:0]  code_q;
  logic [7:0]  err_q;
  logic        drain_pending;

  logic accept;
  logic r_beat;
  logic timed_out;
  logic rsp_done;
  logic drain_done;
  logic expired;

  // Gating with the reset pin keeps req_ready low for the whole time reset is held.
  assign req_ready  = (state == ST_IDLE) && ARESETn;
  assign accept     = req_valid && req_ready;
  assign r_beat     = (state == ST_DATA) && bus.RVALID;
  // A beat arriving on the limit cycle wins over the timeout.
  assign timed_out  = (state == ST_DATA) && !bus.RVALID && expired;
  assign rsp_done   = (state == ST_RESP) && rsp_ready;
  assign drain_done = (state == ST_DRAIN) && bus.RVALID;

  assign bus.ARVALID = (state == ST_ADDR);
  assign bus.ARADDR  = addr_q;
  assign bus.RREADY  = (state == ST_DATA) || (state == ST_DRAIN);

  assign rsp_valid = (state == ST_RESP);
  assign rsp_data  = data_q;
  assign rsp_code  = code_q;
  assign err_count = err_q;

  axi4lite_timeout_ctr u_timeout_ctr (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .clear   (state != ST_DATA),
    .enable  (state == ST_DATA),
    .limit   (LIMIT),
    .expired (expired)
  );

  always_comb begin
    // NOTE: the default assignment up front means every path assigns state_next, so no latch is inferred.
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next = is_aligned(req_addr[1:0]) ? ST_ADDR : ST_RESP;
        end
      end
      ST_ADDR: begin
        if (bus.ARREADY) begin
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (r_beat || timed_out) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_next = drain_pending ? ST_DRAIN : ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (drain_done) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      addr_q        <= '0;
      data_q        <= '0;
      code_q        <= RSP_OK;
      drain_pending <= 1'b0;
    end else begin
      if (accept) begin
        if (is_aligned(req_addr[1:0])) begin
          addr_q <= req_addr;
        end else begin
          data_q <= '0;
          code_q <= RSP_MISALIGNED;
        end
      end
      if (r_beat) begin
        data_q <= bus.RDATA;
        code_q <= rsp_code_of(bus.RRESP);
      end
      // The abandoned read is still owed a beat; remember to swallow it later.
      if (timed_out) begin
        data_q        <= '0;
        code_q        <= RSP_TIMEOUT;
        drain_pending <= 1'b1;
      end
      if (drain_done) begin
        drain_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      err_q <= '0;
    end else if (rsp_done && (code_q != RSP_OK) && (err_q != 8'hFF)) begin
      err_q <= err_q + 8'd1;
    end
  end

endmodule

// File: tb/tb_axi4lite_fetch_master.sv
// Directed bench for axi4lite_fetch_master against a small ROM slave with programmable
// AR/R delays and response code.
module tb_axi4lite_fetch_master;
  import axi4lite_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_code;
  logic [7:0]  err_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Slave configuration and state
  int          ar_wait = 0;
  int          r_wait  = 0;
  logic [1:0]  resp_cfg = RRESP_OKAY;
  logic [31:0] rom [0:7];
  logic        ar_fire = 1'b0;
  logic        r_fire = 1'b0;
  logic        rd_pending = 1'b0;
  int          ar_cnt = 0;
  int          r_cnt = 0;
  int          ar_seen = 0;
  logic [31:0] rd_addr = '0;

  axi4lite_fetch_master_if bus ();

  axi4lite_fetch_master #(.TIMEOUT_CYCLES(16)) dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_code  (rsp_code),
    .err_count (err_count),
    .bus       (bus)
  );

  always #5 ACLK = ~ACLK;

  // Slave decides its drive for the coming rising edge on each falling edge.
  always @(negedge ACLK) begin
    if (!ARESETn) begin
      bus.ARREADY = 1'b0;
      bus.RVALID  = 1'b0;
      bus.RDATA   = '0;
      bus.RRESP   = RRESP_OKAY;
      ar_fire = 1'b0;
      r_fire = 1'b0;
      rd_pending = 1'b0;
      ar_cnt = 0;
      r_cnt = 0;
    end else begin
      if (ar_fire) begin
        rd_pending = 1'b1;
        r_cnt = 0;
        ar_cnt = 0;
      end
      if (r_fire) rd_pending = 1'b0;
      if (bus.ARVALID) ar_seen++;
      bus.ARREADY = 1'b0;
      if (bus.ARVALID) begin
        if (ar_cnt >= ar_wait) begin
          bus.ARREADY = 1'b1;
          rd_addr = bus.ARADDR;
        end else begin
          ar_cnt++;
        end
      end
      ar_fire = bus.ARVALID && bus.ARREADY;
      bus.RVALID = 1'b0;
      bus.RDATA  = '0;
      bus.RRESP  = RRESP_OKAY;
      if (rd_pending) begin
        if (r_cnt >= r_wait) begin
          bus.RVALID = 1'b1;
          bus.RDATA  = rom[rd_addr[4:2]];
          bus.RRESP  = resp_cfg;
        end else begin
          r_cnt++;
        end
      end
      r_fire = bus.RVALID && bus.RREADY;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Called on a falling edge with the DUT idle; returns on the ADDR-cycle falling edge.
  task automatic start_fetch(input logic [31:0] a);
    req_addr  = a;
    req_valid = 1'b1;
    check("req_ready_idle", 32'(req_ready), 32'd1);
    @(negedge ACLK);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int budget);
    int i;
    i = 0;
    while (!rsp_valid && i < budget) begin
      @(negedge ACLK);
      i++;
    end
    check(tag, 32'(rsp_valid), 32'd1);
  endtask

  initial begin
    int n;
    int snap;
    rom[0] = 32'h0000_0000;
    rom[1] = 32'h1234_5678;
    rom[2] = 32'hE59F_1004;
    rom[3] = 32'hA5A5_0003;
    rom[4] = 32'h0000_0125;
    rom[5] = 32'hCAFE_0005;
    rom[6] = 32'h0000_0006;
    rom[7] = 32'h0000_0007;

    // Reset values while reset is held
    @(negedge ACLK);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_arvalid", 32'(bus.ARVALID), 32'd0);
    check("rst_rready", 32'(bus.RREADY), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_code", 32'(rsp_code), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_araddr", bus.ARADDR, 32'd0);
    #2 ARESETn = 1'b1;
    @(negedge ACLK);
    rsp_ready = 1'b1;

    // Aligned fetch, best-case latency
    start_fetch(32'h0000_0008);
    check("t1_arvalid", 32'(bus.ARVALID), 32'd1);
    check("t1_araddr", bus.ARADDR, 32'h0000_0008);
    @(negedge ACLK);
    check("t1_rready", 32'(bus.RREADY), 32'd1);
    check("t1_no_rsp_yet", 32'(rsp_valid), 32'd0);
    @(negedge ACLK);
    check("t1_rsp_valid_lat3", 32'(rsp_valid), 32'd1);
    check("t1_rsp_data", rsp_data, 32'hE59F_1004);
    check("t1_rsp_code", 32'(rsp_code), 32'd0);
    @(negedge ACLK);
    check("t1_rsp_done", 32'(rsp_valid), 32'd0);
    check("t1_err_count", 32'(err_count), 32'd0);

    // Slave error response
    resp_cfg = RRESP_EXOKAY;
    start_fetch(32'h0000_0010);
    wait_rsp("t2_rsp_valid", 10);
    check("t2_rsp_code", 32'(rsp_code), 32'd1);
    check("t2_rsp_data", rsp_data, 32'h0000_0125);
    check("t2_err_before", 32'(err_count), 32'd0);
    @(negedge ACLK);
    check("t2_err_after", 32'(err_count), 32'd1);
    resp_cfg = RRESP_OKAY;

    // Misaligned request never reaches the bus
    snap = ar_seen;
    start_fetch(32'h0000_0006);
    check("t3_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t3_rsp_code", 32'(rsp_code), 32'd3);
    check("t3_rsp_data", rsp_data, 32'd0);
    check("t3_arvalid", 32'(bus.ARVALID), 32'd0);
    @(negedge ACLK);
    check("t3_no_ar", 32'(ar_seen), 32'(snap));
    check("t3_err", 32'(err_count), 32'd2);

    // Timeout with a late beat that must be drained
    r_wait = 20;
    start_fetch(32'h0000_0014);
    @(negedge ACLK);
    n = 0;
    for (int i = 0; i < 40 && !rsp_valid; i++) begin
      if (bus.RREADY) n++;
      @(negedge ACLK);
    end
    check("t4_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t4_data_cycles", 32'(n), 32'd16);
    check("t4_rsp_code", 32'(rsp_code), 32'd2);
    check("t4_rsp_data", rsp_data, 32'd0);
    @(negedge ACLK);
    check("t4_drain_req_ready", 32'(req_ready), 32'd0);
    check("t4_drain_rready", 32'(bus.RREADY), 32'd1);
    n = 0;
    for (int i = 0; i < 40 && !req_ready; i++) begin
      n++;
      @(negedge ACLK);
    end
    check("t4_drain_cycles", 32'(n), 32'd4);
    check("t4_idle", 32'(req_ready), 32'd1);
    check("t4_no_extra_rsp", 32'(rsp_valid), 32'd0);
    check("t4_beat_discarded", rsp_data, 32'd0);
    check("t4_err", 32'(err_count), 32'd3);

    // Beat on the limit cycle is a normal response
    r_wait = 15;
    start_fetch(32'h0000_000C);
    @(negedge ACLK);
    n = 0;
    for (int i = 0; i < 40 && !rsp_valid; i++) begin
      if (bus.RREADY) n++;
      @(negedge ACLK);
    end
    check("t4b_data_cycles", 32'(n), 32'd16);
    check("t4b_rsp_code", 32'(rsp_code), 32'd0);
    check("t4b_rsp_data", rsp_data, 32'hA5A5_0003);
    @(negedge ACLK);
    check("t4b_no_drain", 32'(req_ready), 32'd1);
    check("t4b_err", 32'(err_count), 32'd3);

    // ARREADY stall then response back-pressure
    r_wait = 0;
    ar_wait = 10;
    rsp_ready = 1'b0;
    start_fetch(32'h0000_0004);
    n = 0;
    for (int i = 0; i < 30 && bus.ARVALID; i++) begin
      check("t5_araddr", bus.ARADDR, 32'h0000_0004);
      n++;
      @(negedge ACLK);
    end
    check("t5_addr_cycles", 32'(n), 32'd11);
    @(negedge ACLK);
    for (int i = 0; i < 5; i++) begin
      check("t5_rsp_valid", 32'(rsp_valid), 32'd1);
      check("t5_rsp_data", rsp_data, 32'h1234_5678);
      check("t5_rsp_code", 32'(rsp_code), 32'd0);
      @(negedge ACLK);
    end
    check("t5_rsp_held", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    @(negedge ACLK);
    check("t5_rsp_done", 32'(rsp_valid), 32'd0);
    check("t5_err", 32'(err_count), 32'd3);
    ar_wait = 0;

    // Reset in the data phase
    r_wait = 8;
    start_fetch(32'h0000_0008);
    @(negedge ACLK);
    check("t6_in_data", 32'(bus.RREADY), 32'd1);
    #2 ARESETn = 1'b0;
    #1;
    check("t6_req_ready", 32'(req_ready), 32'd0);
    check("t6_arvalid", 32'(bus.ARVALID), 32'd0);
    check("t6_rready", 32'(bus.RREADY), 32'd0);
    check("t6_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t6_rsp_data", rsp_data, 32'd0);
    check("t6_rsp_code", 32'(rsp_code), 32'd0);
    check("t6_err", 32'(err_count), 32'd0);
    check("t6_araddr", bus.ARADDR, 32'd0);
    @(negedge ACLK);
    #2 ARESETn = 1'b1;
    @(negedge ACLK);
    check("t6_ready_after_rst", 32'(req_ready), 32'd1);
    r_wait = 0;
    start_fetch(32'h0000_0008);
    wait_rsp("t6_rsp_valid", 10);
    check("t6_rsp_data_after", rsp_data, 32'hE59F_1004);
    check("t6_rsp_code_after", 32'(rsp_code), 32'd0);
    @(negedge ACLK);
    check("t6_err_after", 32'(err_count), 32'd0);

    // err_count saturation
    for (int i = 0; i < 254; i++) begin
      req_addr  = 32'h0000_0002;
      req_valid = 1'b1;
      @(negedge ACLK);
      req_valid = 1'b0;
      @(negedge ACLK);
    end
    check("sat_254", 32'(err_count), 32'd254);
    for (int k = 0; k < 2; k++) begin
      req_addr  = 32'h0000_0002;
      req_valid = 1'b1;
      @(negedge ACLK);
      req_valid = 1'b0;
      @(negedge ACLK);
      check("sat_255", 32'(err_count), 32'd255);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
